hsmc_pattern_player: RTL and testbench

//  Parametrised HSMC pin driver: buffers WIDTH-bit pattern words and replays them onto HSMC

---
 rtl/hsmc_pkg.sv | 11 +
 rtl/hsmc_pattern_player_if.sv | 50 +++++
 rtl/hsmc_pattern_ram.sv | 27 ++
 rtl/hsmc_pattern_player.sv | 148 ++++++++++++++
 tb/tb_hsmc_pattern_player.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hsmc_pkg.sv
// rtl/hsmc_pkg.sv - shared types and default sizes for the HSMC pattern player
package hsmc_pkg;

  typedef enum logic {IDLE, PLAY} state_t;

  localparam int HSMC_PAIRS    = 17;
  localparam int DEFAULT_WIDTH = HSMC_PAIRS;
  localparam int DEFAULT_DEPTH = 64;
  localparam int DEFAULT_DIV_W = 16;

endpackage

// File: rtl/hsmc_pattern_player_if.sv
// rtl/hsmc_pattern_player_if.sv - fabric-side bus of the HSMC pattern player
// HSMC_DIFF_PAIR_EN adds the complementary pin_out_n/pin_oe_n lanes.
interface hsmc_pattern_player_if
  import hsmc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int DIV_W = DEFAULT_DIV_W
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_valid;
  logic              wr_ready;
  logic [WIDTH-1:0]  wr_data;
  logic              clr;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [DIV_W-1:0]  rate_div;
  logic [WIDTH-1:0]  oe_mask;
  logic [WIDTH-1:0]  pin_out;
  logic [WIDTH-1:0]  pin_oe;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              err;
`ifdef HSMC_DIFF_PAIR_EN
  logic [WIDTH-1:0]  pin_out_n;
  logic [WIDTH-1:0]  pin_oe_n;

  modport master (
    output wr_valid, wr_data, clr, start, stop, loop_en, rate_div, oe_mask,
    input  wr_ready, pin_out, pin_oe, count, busy, done, err, pin_out_n, pin_oe_n
  );
  modport slave (
    input  wr_valid, wr_data, clr, start, stop, loop_en, rate_div, oe_mask,
    output wr_ready, pin_out, pin_oe, count, busy, done, err, pin_out_n, pin_oe_n
  );
`else
  modport master (
    output wr_valid, wr_data, clr, start, stop, loop_en, rate_div, oe_mask,
    input  wr_ready, pin_out, pin_oe, count, busy, done, err
  );
  modport slave (
    input  wr_valid, wr_data, clr, start, stop, loop_en, rate_div, oe_mask,
    output wr_ready, pin_out, pin_oe, count, busy, done, err
  );
`endif

endinterface

// File: rtl/hsmc_pattern_ram.sv
// rtl/hsmc_pattern_ram.sv - DEPTH x WIDTH pattern store, sync write, sync read, no reset
module hsmc_pattern_ram #(
  parameter int WIDTH  = 17,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/hsmc_pattern_player.sv
// rtl/hsmc_pattern_player.sv - buffers pattern words and replays them onto HSMC pins
// HSMC_DIFF_PAIR_EN drives pin_out_n/pin_oe_n as the true pair complement.
module hsmc_pattern_player
  import hsmc_pkg::*;
#(
  parameter int               WIDTH    = DEFAULT_WIDTH,
  parameter int               DEPTH    = DEFAULT_DEPTH,
  parameter int               DIV_W    = DEFAULT_DIV_W,
  parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
  input  logic               OSC_50_B8A,
  input  logic               RESET,
  hsmc_pattern_player_if.slave bus
);

  localparam int              ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE    = (ADDR_W+1)'(1);

  state_t             state;
  logic [ADDR_W:0]    count;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0]  next_ptr;
  logic [ADDR_W-1:0]  rd_addr;
  logic [DIV_W-1:0]   step;
  logic [DIV_W-1:0]   div_q;
  logic [WIDTH-1:0]   oe_q;
  logic [WIDTH-1:0]   rd_data;
  logic [WIDTH-1:0]   pin_out;
  logic [WIDTH-1:0]   pin_oe;
  logic               wrap_q;
  logic               busy;
  logic               done;
  logic               err;
  logic               wr_ready;
  logic               wr_en;
  logic               rd_en;
  logic               go;
  logic               step_end;
  logic               at_last;

  assign wr_ready = !RESET && (state == IDLE) && !bus.clr && (count < FULL);
  assign wr_en    = bus.wr_valid && wr_ready;
  assign go       = (state == IDLE) && bus.start && !bus.stop && (count != '0);
  assign step_end = (step == div_q);
  assign at_last  = ({1'b0, rd_ptr} == (count - ONE));
  assign next_ptr = at_last ? '0 : rd_ptr + ADDR_W'(1);
  // The RAM read of the next word is issued one cycle before it is loaded onto the pins.
  assign rd_en    = go || ((state == PLAY) && step_end && !bus.stop);
  assign rd_addr  = go ? '0 : next_ptr;

  hsmc_pattern_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (OSC_50_B8A),
    .wr_en   (wr_en),
    .wr_addr (count[ADDR_W-1:0]),
    .wr_data (bus.wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge OSC_50_B8A) begin
    if (RESET) begin
      state   <= IDLE;
      count   <= '0;
      rd_ptr  <= '0;
      step    <= '0;
      div_q   <= '0;
      oe_q    <= '0;
      wrap_q  <= 1'b0;
      pin_out <= IDLE_VAL;
      pin_oe  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clr) begin
            count <= '0;
          end else if (wr_en) begin
            count <= count + ONE;
          end
          if (go) begin
            state  <= PLAY;
            busy   <= 1'b1;
            div_q  <= bus.rate_div;
            oe_q   <= bus.oe_mask;
            rd_ptr <= '0;
            step   <= '0;
            wrap_q <= 1'b0;
          end else if (bus.start && (count == '0)) begin
            err <= 1'b1;
          end
        end
        PLAY: begin
          if (bus.stop) begin
            state   <= IDLE;
            busy    <= 1'b0;
            pin_out <= IDLE_VAL;
            pin_oe  <= '0;
          end else begin
            step <= step_end ? '0 : step + DIV_W'(1);
            if (step_end) begin
              rd_ptr <= next_ptr;
            end
            // wrap_q marks that the word waiting in the RAM is word 0 after the last word.
            if (step == '0) begin
              if (wrap_q && !bus.loop_en) begin
                state   <= IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
                pin_out <= IDLE_VAL;
                pin_oe  <= '0;
              end else begin
                pin_out <= rd_data;
                pin_oe  <= oe_q;
                wrap_q  <= step_end && at_last;
              end
            end else if (step_end) begin
              wrap_q <= at_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_ready = wr_ready;
  assign bus.pin_out  = pin_out;
  assign bus.pin_oe   = pin_oe;
  assign bus.count    = count;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.err      = err;
`ifdef HSMC_DIFF_PAIR_EN
  assign bus.pin_out_n = ~pin_out;
  assign bus.pin_oe_n  = pin_oe;
`endif

endmodule

// File: tb/tb_hsmc_pattern_player.sv
// tb/tb_hsmc_pattern_player.sv - randomized self-checking bench for hsmc_pattern_player
module tb_hsmc_pattern_player;

  localparam int          W      = 17;
  localparam int          D      = 8;
  localparam int          DW     = 8;
  localparam int          CW     = $clog2(D) + 1;
  localparam logic [W-1:0] IDLE_V = 17'h1A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [W-1:0] mdl [$];

  always #5 clk = ~clk;

  hsmc_pattern_player_if #(.WIDTH(W), .DEPTH(D), .DIV_W(DW)) bus ();

  hsmc_pattern_player #(.WIDTH(W), .DEPTH(D), .DIV_W(DW), .IDLE_VAL(IDLE_V)) dut (
    .OSC_50_B8A (clk),
    .RESET      (rst),
    .bus        (bus)
  );

  task automatic write_word(input logic [W-1:0] w);
    logic exp_rdy;
    bus.wr_valid = 1'b1;
    bus.wr_data  = w;
    #1;
    exp_rdy = (mdl.size() < D);
    total++;
    if (bus.wr_ready !== exp_rdy) begin
      bad++;
      $display("FAIL wr_ready got=%0b exp=%0b", bus.wr_ready, exp_rdy);
    end
    if (exp_rdy) mdl.push_back(w);
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    mdl.delete();
  endtask

  // Starts playback and checks every cycle against the word schedule of the model.
  task automatic play(input int r, input bit lp, input int ncyc, input int stop_at);
    logic [W-1:0] oe = W'($urandom);
    int n = mdl.size();
    int hold = r + 1;
    int last = 1 + n * hold;
    bit stopped, playing, showing, exp_done;
    logic [W-1:0] exp_pin, exp_oe;
    bus.rate_div = DW'(r);
    bus.oe_mask  = oe;
    bus.loop_en  = lp;
    bus.start    = 1'b1;
    for (int j = 1; j <= ncyc; j++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.clr = 1'b0;
      bus.wr_valid = 1'b0;
      stopped  = (stop_at > 0) && (j > stop_at);
      playing  = !stopped && (lp || j <= last);
      showing  = playing && (j >= 2);
      exp_pin  = showing ? mdl[((j - 2) / hold) % n] : IDLE_V;
      exp_oe   = showing ? oe : '0;
      exp_done = !lp && !stopped && (j == last + 1);
      total += 4;
      if (bus.pin_out !== exp_pin) begin
        bad++;
        $display("FAIL play_pin_out j=%0d got=%h exp=%h", j, bus.pin_out, exp_pin);
      end
      if (bus.pin_oe !== exp_oe) begin
        bad++;
        $display("FAIL play_pin_oe j=%0d got=%h exp=%h", j, bus.pin_oe, exp_oe);
      end
      if (bus.busy !== playing) begin
        bad++;
        $display("FAIL play_busy j=%0d got=%0b exp=%0b", j, bus.busy, playing);
      end
      if (bus.done !== exp_done) begin
        bad++;
        $display("FAIL play_done j=%0d got=%0b exp=%0b", j, bus.done, exp_done);
      end
`ifdef HSMC_DIFF_PAIR_EN
      total += 2;
      if (bus.pin_out_n !== ~exp_pin) begin
        bad++;
        $display("FAIL play_pin_out_n j=%0d got=%h exp=%h", j, bus.pin_out_n, ~exp_pin);
      end
      if (bus.pin_oe_n !== exp_oe) begin
        bad++;
        $display("FAIL play_pin_oe_n j=%0d got=%h exp=%h", j, bus.pin_oe_n, exp_oe);
      end
`endif
      if (playing) begin
        total++;
        if (bus.wr_ready !== 1'b0) begin
          bad++;
          $display("FAIL play_wr_ready j=%0d got=%0b exp=0", j, bus.wr_ready);
        end
      end
      if (j == 3) begin
        bus.oe_mask  = W'($urandom);
        bus.rate_div = DW'($urandom);
      end
      if (j == 4 && playing) begin
        bus.clr = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data = W'($urandom);
      end
      bus.stop = (j == stop_at);
    end
    @(negedge clk);
    bus.stop = 1'b0;
    bus.clr = 1'b0;
    bus.wr_valid = 1'b0;
    total++;
    if (bus.count !== CW'(n)) begin
      bad++;
      $display("FAIL play_count_kept got=%0d exp=%0d", bus.count, n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total += 7;
    if (bus.pin_out !== IDLE_V) begin bad++; $display("FAIL rst_pin_out got=%h exp=%h", bus.pin_out, IDLE_V); end
    if (bus.pin_oe !== '0) begin bad++; $display("FAIL rst_pin_oe got=%h exp=0", bus.pin_oe); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b exp=0", bus.done); end
    if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", bus.err); end
    if (bus.count !== '0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready got=%0b exp=0", bus.wr_ready); end
    rst = 1'b0;
    #1;
    total++;
    if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL post_rst_wr_ready got=%0b exp=1", bus.wr_ready); end
    @(negedge clk);
  endtask

  task automatic test_oneshot();
    do_clr();
    for (int i = 0; i < 4; i++) write_word(W'(1 << i));
    play(0, 1'b0, 9, 0);
    play(0, 1'b0, 8, 0);
  endtask

  task automatic test_loop_stop();
    play(2, 1'b1, 20, 16);
    do_clr();
    write_word(W'($urandom));
    play(1, 1'b1, 12, 9);
  endtask

  task automatic test_full();
    do_clr();
    for (int i = 0; i <= D; i++) write_word(W'($urandom));
    total++;
    if (bus.count !== CW'(D)) begin bad++; $display("FAIL full_count got=%0d exp=%0d", bus.count, D); end
    play(0, 1'b0, D + 4, 0);
  endtask

  task automatic test_err();
    do_clr();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    total += 2;
    if (bus.err !== 1'b1) begin bad++; $display("FAIL err_pulse got=%0b exp=1", bus.err); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL err_busy got=%0b exp=0", bus.busy); end
    @(negedge clk);
    total++;
    if (bus.err !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%0b exp=0", bus.err); end
    write_word(W'($urandom));
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int j = 0; j < 3; j++) begin
      total += 2;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL startstop_busy got=%0b exp=0", bus.busy); end
      if (bus.pin_out !== IDLE_V) begin bad++; $display("FAIL startstop_pin got=%h exp=%h", bus.pin_out, IDLE_V); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(1, D);
      int r = $urandom_range(0, 3);
      bit lp = $urandom_range(0, 1);
      int len = n * (r + 1);
      do_clr();
      for (int i = 0; i < n; i++) write_word(W'($urandom));
      if (lp) play(r, 1'b1, 2 * len + 6, 2 * len + 3);
      else if ($urandom_range(0, 1) != 0) play(r, 1'b0, len + 4, $urandom_range(1, len + 1));
      else play(r, 1'b0, len + 5, 0);
    end
  endtask

  task automatic test_reset_midplay();
    do_clr();
    for (int i = 0; i < 5; i++) write_word(W'($urandom));
    bus.rate_div = DW'(1);
    bus.loop_en  = 1'b1;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int j = 0; j < 4; j++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mdl.delete();
    total += 5;
    if (bus.pin_out !== IDLE_V) begin bad++; $display("FAIL midrst_pin_out got=%h exp=%h", bus.pin_out, IDLE_V); end
    if (bus.pin_oe !== '0) begin bad++; $display("FAIL midrst_pin_oe got=%h exp=0", bus.pin_oe); end
    if (bus.count !== '0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", bus.count); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b exp=0", bus.busy); end
    if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL midrst_wr_ready got=%0b exp=0", bus.wr_ready); end
`ifdef HSMC_DIFF_PAIR_EN
    total++;
    if (bus.pin_out_n !== ~bus.pin_out) begin bad++; $display("FAIL midrst_pin_out_n got=%h exp=%h", bus.pin_out_n, ~IDLE_V); end
`endif
    rst = 1'b0;
    bus.loop_en = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if (bus.err !== 1'b1) begin bad++; $display("FAIL midrst_empty_err got=%0b exp=1", bus.err); end
    @(negedge clk);
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.clr      = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.loop_en  = 1'b0;
    bus.rate_div = '0;
    bus.oe_mask  = '0;
    test_reset();
    test_oneshot();
    test_loop_stop();
    test_full();
    test_err();
    test_random();
    test_reset_midplay();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
